// File: rtl/iob_native_mem_resp.sv
// rtl/iob_native_mem_resp.sv - IOb native bus memory responder with byte enables and fixed read latency
// Optional pseudo-random back-pressure when IOB_NATIVE_MEM_RESP_STALL_EN is defined.

`ifndef IOB_NATIVE_MEM_RESP_MACROS
`define IOB_NATIVE_MEM_RESP_MACROS
`define REQ_W (1+ADDR_W+DATA_W+DATA_W/8)
`define RESP_W (DATA_W+2)
`define AVALID(I) ((I)*`REQ_W+ADDR_W+DATA_W+DATA_W/8)
`define ADDRESS(I,W) ((I)*`REQ_W+DATA_W+DATA_W/8+(W)-1) -: (W)
`define WDATA(I) ((I)*`REQ_W+DATA_W/8+DATA_W-1) -: DATA_W
`define WSTRB(I) ((I)*`REQ_W+DATA_W/8-1) -: (DATA_W/8)
`define RDATA(I) ((I)*`RESP_W+DATA_W+1) -: DATA_W
`define RVALID(I) ((I)*`RESP_W+1)
`define READY(I) ((I)*`RESP_W)
`endif

module iob_native_mem_resp #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int RD_LAT     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cke_i,
  input  logic [`REQ_W-1:0]    req_i,
  output logic [`RESP_W-1:0]   resp_o
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                r_ready;
  logic                w_ready_nxt;
  logic                r_rvalid;
  logic                w_rvalid_nxt;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   r_mem [0:(1<<MEM_ADDR_W)-1];

  logic                w_avalid;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [NB-1:0]       w_wstrb;
  logic [MEM_ADDR_W-1:0] w_idx;
  logic [ADDR_W-MEM_ADDR_W-1:0] w_unused_addr;
  logic                w_ready;
  logic                w_accept;
  logic                w_rd;
  logic                w_wr;

  assign w_avalid      = req_i[`AVALID(0)];
  assign w_addr        = req_i[`ADDRESS(0,ADDR_W)];
  assign w_wdata       = req_i[`WDATA(0)];
  assign w_wstrb       = req_i[`WSTRB(0)];
  assign w_idx         = w_addr[MEM_ADDR_W+1:2];
  assign w_unused_addr = {w_addr[ADDR_W-1:MEM_ADDR_W+2], w_addr[1:0]};

`ifdef IOB_NATIVE_MEM_RESP_STALL_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_lfsr <= 8'hA5;
    end else if (cke_i) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_ready = r_ready & ~r_lfsr[0];
`else
  assign w_ready = r_ready;
`endif

  // Gate with reset so nothing lands in the RAM on a reset edge
  assign w_accept = w_avalid & w_ready & cke_i & rst_n_i;
  assign w_rd     = w_accept & (w_wstrb == '0);
  assign w_wr     = w_accept & (w_wstrb != '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ready_nxt  = r_ready;
    w_rvalid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_nxt = 1'b1;
        if (w_rd) begin
          if (RD_LAT > 1) begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = 4'(RD_LAT - 1);
            w_ready_nxt = 1'b0;
          end else begin
            w_rvalid_nxt = 1'b1;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = 4'd0;
          w_ready_nxt  = 1'b1;
          w_rvalid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_ready  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (cke_i) begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ready  <= w_ready_nxt;
      r_rvalid <= w_rvalid_nxt;
      if (RD_LAT == 1) begin
        if (w_rd) r_rdata <= r_mem[w_idx];
      end else if (w_rvalid_nxt) begin
        r_rdata <= r_hold;
      end
    end
  end

  // r_hold snapshots the word at acceptance so later writes cannot leak into it
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      for (int i = 0; i < NB; i++) begin
        if (w_wr && w_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
      if (w_rd) r_hold <= r_mem[w_idx];
    end
  end

  assign resp_o = {r_rdata, r_rvalid, w_ready};

endmodule

// File: tb/tb_iob_native_mem_resp.sv
// tb/tb_iob_native_mem_resp.sv - bench for iob_native_mem_resp at read latencies 2, 1 and 4
module tb_iob_native_mem_resp;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        cke   [3];
  logic [68:0] req   [3];
  logic [33:0] resp  [3];

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int lat_of [3] = '{2, 1, 4};
  logic [31:0] model [3][1024];
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  iob_native_mem_resp #(.RD_LAT(2)) u_lat2 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .cke_i(cke[0]), .req_i(req[0]), .resp_o(resp[0]));
  iob_native_mem_resp #(.RD_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .cke_i(cke[1]), .req_i(req[1]), .resp_o(resp[1]));
  iob_native_mem_resp #(.RD_LAT(4)) u_lat4 (
    .clk_i(clk), .rst_n_i(rst_n[2]), .cke_i(cke[2]), .req_i(req[2]), .resp_o(resp[2]));

  function automatic int qsize(input int d);
    case (d)
      0:       qsize = q0.size();
      1:       qsize = q1.size();
      default: qsize = q2.size();
    endcase
  endfunction

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int d, output exp_t e);
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  // Presents one request, waits for it to be accepted, updates model/scoreboard.
  task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input int extra, output int waits);
    int n;
    exp_t e;
    logic [31:0] w;
    logic [9:0] idx;
    req[d] = {1'b1, a, wd, ws};
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (resp[d][0] !== 1'b1 && n < 20);
    chk("accept_ready", {33'b0, resp[d][0]}, 34'd1);
    idx = a[11:2];
    if (ws == 4'h0) begin
      e.d   = model[d][idx];
      e.due = ncyc + lat_of[d] + extra;
      qpush(d, e);
    end else begin
      w = model[d][idx];
      for (int i = 0; i < 4; i++) if (ws[i]) w[8*i +: 8] = wd[8*i +: 8];
      model[d][idx] = w;
    end
    waits = n;
    sync();
    req[d] = '0;
  endtask

  // Scoreboard monitor: every rvalid must match the oldest outstanding read
  initial begin
    exp_t e;
    int   n;
    forever begin
      @(negedge clk);
      ncyc++;
      for (int d = 0; d < 3; d++) begin
        if (resp[d][1] === 1'b1) begin
          n = qsize(d);
          total++;
          assert ((n > 0) === 1'b1) else begin
            bad++;
            $error("FAIL spurious_rvalid dut%0d: got rvalid=1 want none outstanding", d);
          end
          if (n > 0) begin
            qpop(d, e);
            total++;
            assert (resp[d][33:2] === e.d) else begin
              bad++;
              $error("FAIL rdata dut%0d: got %h want %h", d, resp[d][33:2], e.d);
            end
            total++;
            assert (ncyc === e.due) else begin
              bad++;
              $error("FAIL rvalid_cycle dut%0d: got %0d want %0d", d, ncyc, e.due);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      cke[d]   = 1'b1;
      req[d]   = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("reset_resp", resp[d], 34'h0);
    sync();
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("post_reset_ready", {33'b0, resp[d][0]}, 34'd1);
    sync();

    // RD_LAT=2 write/read
    access(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, w);
    access(0, 32'h10, 32'h0, 4'h0, 0, w);
    @(negedge clk);
    #1;
    chk("lat2_busy_ready", {33'b0, resp[0][0]}, 34'd0);
    @(negedge clk);
    #1;
    chk("lat2_rvalid_ready", {32'b0, resp[0][1:0]}, 34'd3);
    sync();
    access(0, 32'h10, 32'h0, 4'hF, 0, w);
    @(negedge clk);
    #1;
    chk("rdata_hold_on_write", {2'b0, resp[0][33:2]}, {2'b0, 32'hDEADBEEF});
    sync();

    // byte enables
    access(0, 32'h20, 32'h11223344, 4'hF, 0, w);
    access(0, 32'h20, 32'hAABBCCDD, 4'b0101, 0, w);
    access(0, 32'h20, 32'h0, 4'h0, 0, w);
    repeat (3) sync();

    // read-after-write in consecutive cycles, then clock-enable freeze mid-read
    access(0, 32'h30, 32'h12345678, 4'hF, 0, w);
    access(0, 32'h30, 32'h0, 4'h0, 0, w);
    repeat (3) sync();
    access(0, 32'h34, 32'h0BADCAFE, 4'hF, 0, w);
    access(0, 32'h34, 32'h0, 4'h0, 3, w);
    cke[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("cke_freeze", {32'b0, resp[0][1:0]}, 34'd0);
      sync();
    end
    cke[0] = 1'b1;
    repeat (4) sync();

    // RD_LAT=1 pipelined reads
    for (int i = 0; i < 4; i++) access(1, 32'(4 * i), 32'(i + 1), 4'hF, 0, w);
    for (int i = 0; i < 4; i++) begin
      access(1, 32'(4 * i), 32'h0, 4'h0, 0, w);
      chk("lat1_ready_const", 34'(w), 34'd1);
    end
    repeat (3) sync();

    // aliasing above MEM_ADDR_W
    access(1, 32'h1000, 32'h5A5A5A5A, 4'hF, 0, w);
    access(1, 32'h0, 32'h0, 4'h0, 0, w);
    repeat (3) sync();

    // RD_LAT=4 reset while busy drops the read
    access(2, 32'h40, 32'hCAFEF00D, 4'hF, 0, w);
    access(2, 32'h40, 32'h0, 4'h0, 0, w);
    rst_n[2] = 1'b0;
    q2.delete();
    repeat (2) sync();
    @(negedge clk);
    #1;
    chk("busy_reset_resp", resp[2], 34'h0);
    sync();
    rst_n[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("busy_reset_ready", {33'b0, resp[2][0]}, 34'd1);
    sync();
    access(2, 32'h40, 32'h0, 4'h0, 0, w);
    repeat (10) sync();

    for (int d = 0; d < 3; d++) chk("queue_drained", 34'(qsize(d)), 34'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
